probe_sample_rx: RTL and testbench

//  Serial receiving end of the logic-probe dump link: deserialises the 8N1 RS-232 byte

---
 rtl/probe_rx_pkg.sv | 28 ++
 rtl/uart_rx_byte.sv | 106 ++++++++++
 rtl/probe_sample_rx.sv | 134 +++++++++++++
 tb/tb_probe_sample_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/probe_rx_pkg.sv
// Shared definitions for the logic-probe sample receiver:
// byte-FSM state encoding, 8N1 framing constants, default divisors.
package probe_rx_pkg;

  // 8N1 framing
  localparam int DATA_BITS = 8;

  // 50 MHz / 115200 baud
  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DEF_SAMPLE_BYTES = 16;
  localparam int DEF_TIMEOUT_BITS = 20;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

  // Saturating 16-bit increment for the error counter.
  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop rxd synchroniser plus byte FSM.
// Ports: clk, reset (sync, active high), rxd_i (async serial in),
//   byte_o / byte_strobe_o (accepted byte, 1-cycle strobe),
//   frame_err_o (1-cycle pulse, stop bit low), busy_o (FSM not idle).
module uart_rx_byte
  import probe_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       byte_strobe_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] DBIT_LAST = BIT_W'(DATA_BITS - 1);

  rx_state_e      state_q;
  logic [1:0]     sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BIT_W-1:0] bit_q;
  logic [7:0]     shift_q;
  logic [7:0]     byte_q;
  logic           strobe_q;
  logic           ferr_q;
  logic           rxd_s;

  assign rxd_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= 2'b11;
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      strobe_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], rxd_i};
      strobe_q <= 1'b0;
      ferr_q   <= 1'b0;
      unique case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          // Line only reaches IDLE while high, so low here is a falling edge.
          if (!rxd_s) state_q <= RX_START;
        end
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            bit_q <= '0;
            // High at mid start bit: treat as a glitch.
            state_q <= rxd_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rxd_s, shift_q[7:1]};
            if (bit_q == DBIT_LAST) state_q <= RX_STOP;
            else bit_q <= bit_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rxd_s) begin
              byte_q   <= shift_q;
              strobe_q <= 1'b1;
              state_q  <= RX_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= RX_WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_WAIT_IDLE: begin
          cnt_q <= '0;
          if (rxd_s) state_q <= RX_IDLE;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_o        = byte_q;
  assign byte_strobe_o = strobe_q;
  assign frame_err_o   = ferr_q;
  assign busy_o        = (state_q != RX_IDLE);

endmodule

// File: rtl/probe_sample_rx.sv
// Logic-probe dump receiver: 8N1 bytes assembled into W-bit samples
// with valid/ready output, frame-error pulse, sticky overrun, idle timeout.
// Ports: clk, reset (sync, active high), rs232_rxd, sample_data/
//   sample_valid/sample_ready, frame_err, overrun,
//   err_count (only when PROBE_RX_ERRCNT_EN is defined).
module probe_sample_rx
  import probe_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int SAMPLE_BYTES = DEF_SAMPLE_BYTES,
  parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rs232_rxd,
  output logic [8*SAMPLE_BYTES-1:0] sample_data,
  output logic                      sample_valid,
  input  logic                      sample_ready,
`ifdef PROBE_RX_ERRCNT_EN
  output logic [15:0]               err_count,
`endif
  output logic                      frame_err,
  output logic                      overrun
);

  localparam int W        = 8 * SAMPLE_BYTES;
  localparam int IDX_W    = $clog2(SAMPLE_BYTES) + 1;
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = (TO_LIMIT > 1) ? $clog2(TO_LIMIT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLE_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_LIMIT - 1);

  logic [7:0]       rx_byte;
  logic             rx_strobe;
  logic             rx_ferr;
  logic             rx_busy;

  logic [W-1:0]     hold_q, hold_d;
  logic [W-1:0]     data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [W-1:0]     shifted;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk          (clk),
    .reset        (reset),
    .rxd_i        (rs232_rxd),
    .byte_o       (rx_byte),
    .byte_strobe_o(rx_strobe),
    .frame_err_o  (rx_ferr),
    .busy_o       (rx_busy)
  );

  // First byte received ends up in the top byte lane.
  assign shifted = (hold_q << 8) | W'(rx_byte);

  always_comb begin
    hold_d  = hold_q;
    data_d  = data_q;
    idx_d   = idx_q;
    to_d    = to_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (valid_q && sample_ready) valid_d = 1'b0;

    if (rx_ferr) begin
      idx_d = '0;
      to_d  = '0;
    end else if (rx_strobe) begin
      hold_d = shifted;
      to_d   = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        // Accepting the old sample this cycle frees the slot: no bubble.
        if (!valid_q || sample_ready) begin
          data_d  = shifted;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (idx_q == '0 || rx_busy) begin
      // Timeout only runs on an idle line with a partial sample.
      to_d = '0;
    end else if (to_q == TO_LAST) begin
      idx_d = '0;
      to_d  = '0;
    end else begin
      to_d = to_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      to_q    <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;
  assign frame_err    = rx_ferr;

`ifdef PROBE_RX_ERRCNT_EN
  logic [15:0] errcnt_q;

  always_ff @(posedge clk) begin
    if (reset) errcnt_q <= '0;
    else if (rx_ferr) errcnt_q <= sat_inc16(errcnt_q);
  end

  assign err_count = errcnt_q;
`endif

endmodule

// File: tb/tb_probe_sample_rx.sv
// Randomised scoreboard bench for probe_sample_rx
// (CLKS_PER_BIT=8, SAMPLE_BYTES=16, TIMEOUT_BITS=20).
module tb_probe_sample_rx;

  localparam int CPB = 8;
  localparam int SB  = 16;
  localparam int TOB = 20;
  localparam int W   = 8 * SB;

  logic         clk = 1'b0;
  logic         reset;
  logic         rs232_rxd;
  logic         sample_ready;
  logic [W-1:0] sample_data;
  logic         sample_valid;
  logic         frame_err;
  logic         overrun;
`ifdef PROBE_RX_ERRCNT_EN
  logic [15:0]  err_count;
`endif

  always #5 clk = ~clk;

  probe_sample_rx #(
    .CLKS_PER_BIT(CPB),
    .SAMPLE_BYTES(SB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rs232_rxd   (rs232_rxd),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
`ifdef PROBE_RX_ERRCNT_EN
    .err_count   (err_count),
`endif
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  logic [W-1:0] exp_q[$];
  logic [7:0]   part[$];
  bit           exp_ovr = 1'b0;
  int           exp_ferr = 0;
  int           exp_errcnt = 0;
  int           exp_acc = 0;

  // Observed
  int           ferr_seen = 0;
  int           n_acc = 0;

  task automatic chk(input string name, input logic [W-1:0] got,
                     input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: sampled on negedge, inputs change just after posedge.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) ferr_seen++;
      if (sample_valid && sample_ready) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_sample: got %0h want none", sample_data);
        end else begin
          chk("sample", sample_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Byte-level model: 16 good bytes make a sample, first byte on top;
  // a bad stop bit throws away the partial sample.
  task automatic model_byte(input logic [7:0] b, input bit ok);
    logic [W-1:0] s;
    if (!ok) begin
      part.delete();
      exp_ferr++;
      if (exp_errcnt < 16'hFFFF) exp_errcnt++;
      return;
    end
    part.push_back(b);
    if (part.size() == SB) begin
      s = '0;
      for (int i = 0; i < SB; i++) s[W-1-8*i -: 8] = part[i];
      part.delete();
      if (!sample_ready && exp_q.size() > 0) exp_ovr = 1'b1;
      else begin
        exp_q.push_back(s);
        exp_acc++;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok);
    model_byte(b, ok);
    rs232_rxd = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rs232_rxd = b[i];
      cyc(CPB);
    end
    rs232_rxd = ok;
    cyc(CPB);
    rs232_rxd = 1'b1;
    cyc(2);
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
  endtask

  task automatic idle(input int n);
    rs232_rxd = 1'b1;
    cyc(n);
    if (n >= TOB * CPB) part.delete();
  endtask

  task automatic drain();
    for (int k = 0; k < 400; k++) begin
      if (exp_q.size() == 0) break;
      cyc(1);
    end
    chk("drain", W'(exp_q.size()), '0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rs232_rxd = 1'b1;
    cyc(3);
    reset = 1'b0;
    part.delete();
    exp_q.delete();
    exp_ovr = 1'b0;
    exp_errcnt = 0;
  endtask

  function automatic logic [31:0] lfsr(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'hA3000000) : (x >> 1);
  endfunction

  task automatic check_ctl(input string tag);
    chk({tag, "_overrun"}, W'(overrun), W'(exp_ovr));
    chk({tag, "_ferr_pulses"}, W'(ferr_seen), W'(exp_ferr));
`ifdef PROBE_RX_ERRCNT_EN
    chk({tag, "_err_count"}, W'(err_count), W'(exp_errcnt));
`endif
  endtask

  initial begin
    logic [31:0] seeds[4];
    logic [31:0] x;
    seeds = '{32'hC70337DB, 32'h7F4D514F, 32'h75377599, 32'h7D5937A3};

    reset = 1'b1;
    rs232_rxd = 1'b1;
    sample_ready = 1'b0;
    cyc(4);
    chk("rst_valid", W'(sample_valid), '0);
    chk("rst_data", sample_data, '0);
    chk("rst_ferr", W'(frame_err), '0);
    reset = 1'b0;
    cyc(1);
    check_ctl("rst");

    // 1: counting bytes
    sample_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
    drain();
    chk("t1_acc", W'(n_acc), W'(exp_acc));
    check_ctl("t1");

    // 2: LFSR bytes, sink stalled across two completions
    sample_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      x = seeds[s];
      for (int j = 0; j < 8; j++) begin
        x = lfsr(x);
        send_byte(x[7:0], 1'b1);
      end
    end
    chk("t2_valid", W'(sample_valid), W'(1));
    chk("t2_held", sample_data, exp_q[0]);
    check_ctl("t2");
    sample_ready = 1'b1;
    drain();
    chk("t2_acc", W'(n_acc), W'(exp_acc));

    // 3: framing error mid-sample
    send_rand(3);
    send_byte(8'h55, 1'b0);
    check_ctl("t3");
    send_rand(16);
    drain();

    // 4: idle timeout drops a partial sample
    send_rand(5);
    idle(200);
    for (int i = 0; i < 16; i++) send_byte(8'hAA, 1'b1);
    drain();
    chk("t4_acc", W'(n_acc), W'(exp_acc));

    // 5: short low glitch inside a sample
    send_rand(4);
    rs232_rxd = 1'b0;
    cyc(3);
    rs232_rxd = 1'b1;
    cyc(40);
    check_ctl("t5");
    send_rand(12);
    drain();

    // 6: reset during byte 7
    send_rand(6);
    rs232_rxd = 1'b0;
    cyc(CPB);
    rs232_rxd = 1'b1;
    cyc(CPB + 3);
    do_reset();
    chk("t6_valid", W'(sample_valid), '0);
    chk("t6_data", sample_data, '0);
    check_ctl("t6");
    idle(20);
    send_rand(16);
    drain();

    chk("end_acc", W'(n_acc), W'(exp_acc));
    check_ctl("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
